// File: rtl/smg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: drives one active-low segment bus across NDIG
// active-low digit selects, with frame-consistent shadow codes loaded via req/ack.
module smg_scan_ctrl #(
  parameter int NDIG    = 6,
  parameter int T_DWELL = 49_999,
  parameter int T_BLANK = 499
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              enable,
  input  logic              load_req,
  input  logic [8*NDIG-1:0] load_data,
  output logic              load_ack,
  output logic [7:0]        Row_Scan_Sig,
  output logic [NDIG-1:0]   Column_Scan_Sig,
  output logic              frame_done,
  output logic [1:0]        dbg_state
);

  localparam int TMAX = (T_DWELL > T_BLANK) ? T_DWELL : T_BLANK;
  localparam int CW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
  localparam int IW   = $clog2(NDIG);
  localparam logic [CW-1:0] DWELL_LIM = CW'(T_DWELL);
  localparam logic [CW-1:0] BLANK_LIM = CW'(T_BLANK);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, BLANK = 2'd2} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [7:0]    shadow  [NDIG];
  logic [7:0]    pending [NDIG];
  logic          pend_valid;
  logic          boundary;
  logic          wrap_q;
  logic [7:0]    row_nx;
  logic [NDIG-1:0] col_nx;
  logic          fd_nx;

  assign dbg_state = state;
  assign boundary  = enable && (state == BLANK) && (cnt == BLANK_LIM) && (idx == LAST_IDX);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = SHOW;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
        SHOW: begin
          if (cnt == DWELL_LIM) begin
            state_nx = BLANK;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        BLANK: begin
          if (cnt == BLANK_LIM) begin
            state_nx = SHOW;
            cnt_nx   = '0;
            idx_nx   = (idx == LAST_IDX) ? '0 : idx + IW'(1);
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
          idx_nx   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the current state, so digit data and column select move together.
  always_comb begin
    row_nx = 8'hFF;
    col_nx = '1;
    fd_nx  = wrap_q && enable;
    if (enable && (state == SHOW)) begin
      row_nx = shadow[idx];
      col_nx = ~(NDIG'(1) << idx);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Row_Scan_Sig    <= 8'hFF;
      Column_Scan_Sig <= '1;
      frame_done      <= 1'b0;
      wrap_q          <= 1'b0;
    end else begin
      Row_Scan_Sig    <= row_nx;
      Column_Scan_Sig <= col_nx;
      frame_done      <= fd_nx;
      wrap_q          <= boundary;
    end
  end

  // Handshake: load_req is a level held with stable load_data until load_ack; a request is
  // captured only while pending is empty, and load_ack pulses the cycle after capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      shadow     <= '{default: 8'hFF};
      pending    <= '{default: 8'hFF};
      pend_valid <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (pend_valid && (boundary || (state == IDLE))) begin
        shadow     <= pending;
        pend_valid <= 1'b0;
      end else if (load_req && !pend_valid) begin
        for (int k = 0; k < NDIG; k++) pending[k] <= load_data[8*k +: 8];
        pend_valid <= 1'b1;
        load_ack   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_smg_scan_ctrl.sv
// Bench for smg_scan_ctrl with a small geometry (4 digits, 10-cycle dwell, 2-cycle blank).
module tb_smg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int TD   = 9;
  localparam int TB   = 1;
  localparam int DP   = TD + TB + 2;
  localparam int FP   = NDIG * DP;

  localparam logic [31:0] CODES_A = {8'hB0, 8'hA4, 8'hF9, 8'hC0};
  localparam logic [31:0] CODES_B = {8'h99, 8'h92, 8'h82, 8'hF8};
  localparam logic [31:0] CODES_C = {8'h80, 8'h90, 8'h88, 8'h83};
  localparam logic [31:0] CODES_D = {8'hC6, 8'hA1, 8'h86, 8'h8E};
  localparam logic [31:0] CODES_E = {8'h11, 8'h22, 8'h33, 8'h44};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        enable = 1'b0;
  logic        load_req = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ack;
  logic [7:0]  Row_Scan_Sig;
  logic [3:0]  Column_Scan_Sig;
  logic        frame_done;
  logic [1:0]  dbg_state;

  logic [12:0] exp_q[$];
  logic [12:0] got, exp_v;
  int errors = 0;
  int checks = 0;

  smg_scan_ctrl #(.NDIG(NDIG), .T_DWELL(TD), .T_BLANK(TB)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .load_req(load_req), .load_data(load_data),
    .load_ack(load_ack), .Row_Scan_Sig(Row_Scan_Sig), .Column_Scan_Sig(Column_Scan_Sig),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic void push_dark(input int n);
    repeat (n) exp_q.push_back({1'b0, 4'hF, 8'hFF});
  endfunction

  // Expected {frame_done, column, row} per cycle: dwell TD+1 cycles, then TB+1 blank cycles.
  function automatic void push_frame(input logic [31:0] codes, input logic fd_first, input int n);
    for (int s = 0; s < n; s++) begin
      int d, r;
      logic [3:0] col;
      logic [7:0] row;
      logic fd;
      d   = s / DP;
      r   = s % DP;
      fd  = (s == 0) ? fd_first : 1'b0;
      col = 4'hF;
      row = 8'hFF;
      if (r <= TD) begin
        col[d] = 1'b0;
        row    = codes[8*d +: 8];
      end
      exp_q.push_back({fd, col, row});
    end
  endfunction

  task automatic test_reset();
    RST = 1'b1; enable = 1'b0; load_req = 1'b0;
    step();
    checks++;
    if ({frame_done, Column_Scan_Sig, Row_Scan_Sig, load_ack} !== 14'h1FFE) begin
      errors++;
      $display("FAIL reset_hold: got %h exp 1ffe", {frame_done, Column_Scan_Sig, Row_Scan_Sig, load_ack});
    end
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if ({frame_done, Column_Scan_Sig, Row_Scan_Sig, load_ack} !== 14'h1FFE) begin
        errors++;
        $display("FAIL idle_dark[%0d]: got %h exp 1ffe", i, {frame_done, Column_Scan_Sig, Row_Scan_Sig, load_ack});
      end
    end
  endtask

  task automatic test_idle_load(input logic [31:0] codes);
    load_data = codes;
    load_req  = 1'b1;
    step();
    checks++;
    if (load_ack !== 1'b1) begin
      errors++;
      $display("FAIL idle_ack: got %b exp 1", load_ack);
    end
    load_req = 1'b0;
    step();
    checks++;
    if (load_ack !== 1'b0) begin
      errors++;
      $display("FAIL idle_ack_pulse: got %b exp 0", load_ack);
    end
  endtask

  task automatic test_frame_load();
    push_dark(1);
    push_frame(CODES_A, 1'b0, FP);
    push_frame(CODES_B, 1'b1, FP);
    enable = 1'b1;
    for (int k = 0; exp_q.size() != 0; k++) begin
      step();
      got   = {frame_done, Column_Scan_Sig, Row_Scan_Sig};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL frame_load[%0d]: got %h exp %h", k, got, exp_v);
      end
      if (k == 17 || k == 18) begin
        checks++;
        if (load_ack !== (k == 17)) begin
          errors++;
          $display("FAIL frame_load_ack[%0d]: got %b exp %b", k, load_ack, (k == 17));
        end
      end
      if (k == 16) begin
        load_data = CODES_B;
        load_req  = 1'b1;
      end
      if (k == 17) load_req = 1'b0;
    end
    enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    push_dark(1);
    push_frame(CODES_B, 1'b0, FP);
    push_frame(CODES_C, 1'b1, FP);
    push_frame(CODES_D, 1'b1, FP);
    enable = 1'b1;
    for (int k = 0; exp_q.size() != 0; k++) begin
      step();
      got   = {frame_done, Column_Scan_Sig, Row_Scan_Sig};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL b2b[%0d]: got %h exp %h", k, got, exp_v);
      end
      if (k == 7 || (k >= 10 && k <= 50)) begin
        checks++;
        if (load_ack !== (k == 7 || k == 49)) begin
          errors++;
          $display("FAIL b2b_ack[%0d]: got %b exp %b", k, load_ack, (k == 7 || k == 49));
        end
      end
      if (k == 6) begin
        load_data = CODES_C;
        load_req  = 1'b1;
      end
      if (k == 7) load_req = 1'b0;
      if (k == 9) begin
        load_data = CODES_D;
        load_req  = 1'b1;
      end
      if (k == 49) load_req = 1'b0;
    end
    enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_enable_drop();
    push_dark(1);
    push_frame(CODES_D, 1'b0, 27);
    push_dark(60);
    push_dark(1);
    push_frame(CODES_D, 1'b0, FP);
    enable = 1'b1;
    for (int k = 0; exp_q.size() != 0; k++) begin
      step();
      got   = {frame_done, Column_Scan_Sig, Row_Scan_Sig};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL enable_drop[%0d]: got %h exp %h", k, got, exp_v);
      end
      if (k == 27) enable = 1'b0;
      if (k == 87) enable = 1'b1;
    end
    enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_mid();
    push_dark(1);
    push_frame(CODES_D, 1'b0, 15);
    enable = 1'b1;
    for (int k = 0; exp_q.size() != 0; k++) begin
      step();
      got   = {frame_done, Column_Scan_Sig, Row_Scan_Sig};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got %h exp %h", k, got, exp_v);
      end
      if (k == 5) begin
        checks++;
        if (load_ack !== 1'b1) begin
          errors++;
          $display("FAIL reset_mid_ack: got %b exp 1", load_ack);
        end
        load_req = 1'b0;
      end
      if (k == 4) begin
        load_data = CODES_E;
        load_req  = 1'b1;
      end
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({frame_done, Column_Scan_Sig, Row_Scan_Sig} !== 13'h0FFF) begin
      errors++;
      $display("FAIL async_reset: got %h exp 0fff", {frame_done, Column_Scan_Sig, Row_Scan_Sig});
    end
    enable = 1'b0;
    step();
    RST = 1'b0;
    step();
    step();
    push_dark(1);
    push_frame(32'hFFFF_FFFF, 1'b0, FP);
    enable = 1'b1;
    for (int k = 0; exp_q.size() != 0; k++) begin
      step();
      got   = {frame_done, Column_Scan_Sig, Row_Scan_Sig};
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL post_reset[%0d]: got %h exp %h", k, got, exp_v);
      end
    end
    enable = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_idle_load(CODES_A);
    test_frame_load();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smg_scan_ctrl.md
# smg_scan_ctrl

Multiplexed seven-segment scan controller that time-shares one 8-bit segment bus across NDIG digit positions. It holds a frame-consistent shadow copy of all digit codes and accepts new codes through a req/ack handshake, applying them only at frame boundaries. Each digit is driven for a dwell period followed by a blanking gap that suppresses ghosting. It sits between the digit encoders and the board's segment/column pins.

## Interface
- NDIG, 6, number of digit positions (2..8)
- T_DWELL, 49_999, dwell count; each digit is shown for T_DWELL+1 cycles (1 ms at 50 MHz)
- T_BLANK, 499, blank count; gap of T_BLANK+1 cycles between digits
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = scanning, 0 = display dark
- load_req  in  1  level request to load a new frame
- load_data  in  8*NDIG  segment codes; digit k in bits [8k+7:8k]; active-low segments
- load_ack  out  1  one-cycle pulse: load_data captured
- Row_Scan_Sig  out  8  segment drive, active-low (8'hFF = all off)
- Column_Scan_Sig  out  NDIG  digit select, active-low one-cold; all ones = none selected
- frame_done  out  1  one-cycle pulse at the end of each full frame

## Operation
- Storage: shadow[NDIG] (displayed), pending[NDIG] plus pend_valid flag.
- Load handshake: in any cycle with load_req=1 and pend_valid=0, capture load_data into pending and set pend_valid. load_ack pulses the following cycle. While pend_valid=1, load_req is ignored and no ack is issued; the requester holds req and data stable until ack.
- Transfer: pending -> shadow and pend_valid cleared (a) at the frame boundary (last cycle of BLANK for digit NDIG-1), or (b) on any cycle in IDLE. A load_req in the transfer cycle is accepted in the next cycle, never the same cycle.
- FSM states: IDLE, SHOW, BLANK.
  - IDLE: Column all ones, Row 8'hFF, idx=0, counter=0. enable=1 -> SHOW.
  - SHOW: Column bit idx low, Row = shadow[idx]. When counter==T_DWELL -> BLANK, counter=0.
  - BLANK: Column all ones, Row 8'hFF. When counter==T_BLANK -> SHOW with idx+1, or idx=0 if idx==NDIG-1 (wrap; frame_done pulses, transfer applies).
  - enable=0 in any state -> IDLE next cycle, idx and counter cleared; the partial frame gives no frame_done.
- Counter width: clog2(max(T_DWELL,T_BLANK)+1); counts 0..limit inclusive, never overflows.

## Timing
- All outputs registered; reset values: Row_Scan_Sig=8'hFF, Column_Scan_Sig=all ones, load_ack=0, frame_done=0; shadow=all 8'hFF, pend_valid=0, state IDLE, idx=0.
- enable rises in cycle n -> digit 0 shown on the outputs from cycle n+2.
- Digit period = T_DWELL+T_BLANK+2 cycles; frame period = NDIG*(T_DWELL+T_BLANK+2).
- frame_done is registered together with the transition into SHOW of digit 0, so it is high in the same cycle digit 0 first appears with the new shadow.
- Column and Row change in the same cycle; there is never a cycle where a column is selected with stale segment data.
- RST mid-frame: all state returns to reset values immediately (asynchronously); pending data is discarded.

## Test plan
- Reset/idle: RST=1, then RST=0 with enable=0 -> Row=8'hFF, Column=all ones, load_ack=0 indefinitely.
- Scan order (NDIG=4, T_DWELL=9, T_BLANK=1, shadow loaded with 8'hC0,8'hF9,8'hA4,8'hB0): enable=1 -> Column 1110 for 10 cycles with Row=8'hC0, then 2 blank cycles, then 1101 with 8'hF9, ..., frame_done every 48 cycles.
- Frame-boundary load: req mid-frame with new codes -> ack one cycle later; digits already shown keep old codes until frame_done, then all four update together.
- Back-pressure: second req while pend_valid=1 -> no ack until the cycle after the boundary transfer, then ack; second data appears one frame later.
- Idle load: enable=0, req -> ack next cycle; enable=1 -> first frame shows the new data.
- Enable drop/reset mid-frame: enable=0 during digit 2 -> outputs dark next cycle, no frame_done; re-enable restarts at digit 0. RST during SHOW -> outputs dark, shadow=8'hFF.
